// File: rtl/aes_pkg.sv
// Purpose: shared AES constants, FSM state type and GF(2^8) helpers.
// Latency: n/a (package, combinational helper functions only).
// Backpressure: n/a.
package aes_pkg;

   // Reduction constant for x^8+x^4+x^3+x+1 after dropping the x^8 term.
   localparam logic [7:0] GF_POLY = 8'h1b;
   // Number of 32-bit columns in an AES state.
   localparam int         NB      = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Multiply by x in GF(2^8).
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
   endfunction

   // General GF(2^8) multiply; with a constant b it reduces to a small XOR tree.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

endpackage

// File: rtl/inv_mix_single_column.sv
// Purpose: InvMixColumns on one 32-bit column (row 0 in the MSB byte).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of col_in.
// Ports: col_in [31:0] column to transform, col_out [31:0] transformed column.
module inv_mix_single_column
   import aes_pkg::*;
(
   input  logic [31:0] col_in,
   output logic [31:0] col_out
);

   logic [7:0] a0, a1, a2, a3;

   assign {a0, a1, a2, a3} = col_in;

   assign col_out[31:24] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
   assign col_out[23:16] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
   assign col_out[15:8]  = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
   assign col_out[7:0]   = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Purpose: iterative AES InvMixColumns, COLS_PER_CYCLE columns per BUSY cycle (1, 2 or 4).
// Latency: 4/COLS_PER_CYCLE edges from acceptance to out_valid; one state in flight.
// Backpressure: result held stable in DONE until out_ready; in_ready low until then.
// Ports: clk, rst (sync, active-high), in_valid/in_ready/in_state[127:0],
//        out_valid/out_ready/out_state[127:0] (column c at bits [127-32c -: 32]).
module inv_mix_columns_iter
   import aes_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state
);

   state_t      state_q;
   logic [1:0]  cnt_q;
   logic [31:0] cols_q  [NB];
   logic [31:0] col_res [COLS_PER_CYCLE];
   logic [2:0]  cnt_nxt;

   // One extra bit so the final step (cnt + step == 4) is detectable without wrapping.
   assign cnt_nxt = {1'b0, cnt_q} + 3'(COLS_PER_CYCLE);

   // cnt_q is always a multiple of COLS_PER_CYCLE, so cnt_q + k never passes column 3.
   for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
      logic [1:0] idx;
      assign idx = cnt_q + 2'(k);
      inv_mix_single_column u_col (
         .col_in  (cols_q[idx]),
         .col_out (col_res[k])
      );
   end

   assign out_state = {cols_q[0], cols_q[1], cols_q[2], cols_q[3]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         for (int c = 0; c < NB; c++) cols_q[c] <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  for (int c = 0; c < NB; c++) cols_q[c] <= in_state[127-32*c -: 32];
                  cnt_q    <= '0;
                  in_ready <= 1'b0;
                  state_q  <= BUSY;
               end
            end
            BUSY: begin
               for (int k = 0; k < COLS_PER_CYCLE; k++) cols_q[cnt_q + 2'(k)] <= col_res[k];
               if (cnt_nxt == 3'(NB)) begin
                  cnt_q     <= '0;
                  out_valid <= 1'b1;
                  state_q   <= DONE;
               end else begin
                  cnt_q <= cnt_nxt[1:0];
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state_q   <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state_q   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/inv_mix_columns_iter.md
INV_MIX_COLUMNS_ITER -- requirements
Module: inv_mix_columns_iter

Interface
REQ-001 Parameter COLS_PER_CYCLE, default 1: columns transformed per BUSY cycle; legal values 1, 2, 4.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  in_state is valid.
REQ-005 in_ready  output  1  block can accept a state.
REQ-006 in_state  input  128  AES state; column c at bits [127-32c -: 32]; row 0 is the MSB byte of each column.
REQ-007 out_valid  output  1  out_state holds a completed result.
REQ-008 out_ready  input  1  downstream accepts out_state.
REQ-009 out_state  output  128  InvMixColumns(in_state), same column and byte layout as in_state.

Function
REQ-010 Each column (a0,a1,a2,a3) SHALL map to r0=0e·a0^0b·a1^0d·a2^09·a3, r1=09·a0^0e·a1^0b·a2^0d·a3, r2=0d·a0^09·a1^0e·a2^0b·a3, r3=0b·a0^0d·a1^09·a2^0e·a3, all in GF(2^8) modulo x^8+x^4+x^3+x+1 (reduction constant 8'h1b).
REQ-011 All byte arithmetic SHALL be 8 bits wide; xtime SHALL shift left by 1 and XOR 8'h1b when the pre-shift MSB is 1.
REQ-012 FSM states SHALL be IDLE, BUSY and DONE.
REQ-013 IDLE: in_ready=1; on in_valid&&in_ready the block SHALL latch in_state into an internal 128-bit register, clear the column counter to 0 and enter BUSY.
REQ-014 BUSY: in_ready=0, out_valid=0; each cycle the block SHALL replace columns cnt..cnt+COLS_PER_CYCLE-1 in place and advance cnt by COLS_PER_CYCLE.
REQ-015 When the column just processed is column 3, the block SHALL enter DONE on that edge; the counter SHALL NOT wrap into a fifth column.
REQ-016 Latency SHALL be 4/COLS_PER_CYCLE edges from the acceptance edge to the first cycle with out_valid=1.
REQ-017 DONE: out_valid=1, in_ready=0; out_state SHALL be stable while out_valid=1 and out_ready=0, for any duration.
REQ-018 DONE with out_ready=1: the block SHALL return to IDLE on that edge; a new input is accepted no earlier than the following cycle (no overlap).
REQ-019 in_valid and in_state SHALL be ignored outside IDLE; out_ready SHALL be ignored outside DONE.
REQ-020 out_state SHALL be driven directly from the internal register; its value is don't-care while out_valid=0.

Reset
REQ-021 rst=1 at any edge SHALL force IDLE, counter=0, internal register=0, out_valid=0, and in_ready=1 from the next cycle.
REQ-022 rst asserted during BUSY or DONE SHALL abort the operation with no output handshake; a result pending in DONE is discarded.
REQ-023 rst SHALL take priority over simultaneous in_valid or out_ready.

Structure
REQ-024 Shared package aes_pkg SHALL hold the GF reduction constant 8'h1b, the column count NB=4, the FSM state typedef, and the xtime/gmul helper functions.
REQ-025 One combinational sub-module, inv_mix_single_column (32-bit in, 32-bit out, coefficients 0e/0b/0d/09), SHALL be instantiated COLS_PER_CYCLE times.
REQ-026 The datapath SHALL contain no other storage than the 128-bit state register, the counter and the FSM register.

Verification
REQ-027 Single column vectors, all four column slots: 8e4da1bc->db135345, 9fdc589d->f20a225c, 01010101->01010101, c6c6c6c6->c6c6c6c6, d5d5d7d6->d4d4d4d5, 4d7ebdf8->2d26314c.
REQ-028 Full state in_state=8e4da1bc_9fdc589d_01010101_d5d5d7d6 with COLS_PER_CYCLE=1 -> out_state=db135345_f20a225c_01010101_d4d4d4d5, out_valid rising exactly 4 edges after acceptance; repeat with COLS_PER_CYCLE=2 (2 edges) and 4 (1 edge).
REQ-029 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid=1 and out_state constant throughout, in_ready=0; then out_ready=1 -> IDLE next cycle.
REQ-030 Reset mid-BUSY (assert at counter=2) -> next cycle in_ready=1, out_valid=0; a fresh input then completes correctly.
REQ-031 Round trip: 1000 random states through the MixColumns reference model then this block -> output equals original state; in_valid toggled randomly during BUSY/DONE has no effect.
